// File: rtl/cla_flow_alloc_age_pkg.sv
// ---------------------------------------------------------------------------
// cla_flow_alloc_age_pkg
// Shared definitions for the flow-entry allocator / aging engine:
//   - default widths (pointer width, timestamp width, idle timeout)
//   - controller state encoding (CLEAR / IDLE / SCAN_RD / SCAN_EVAL)
//   - table entry layout, packed as {active, ts[TS_NBITS-1:0]}
//   - helper that applies the wrap-around expiry rule to an entry
// No ports; imported by cla_flow_alloc_age and cla_flow_age_ram users.
// ---------------------------------------------------------------------------
package cla_flow_alloc_age_pkg;

  localparam int unsigned BPTR_NBITS_DEF  = 4;
  localparam int unsigned TS_NBITS_DEF    = 8;
  localparam int unsigned AGE_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SCAN_RD   = 2'd2,
    ST_SCAN_EVAL = 2'd3
  } AgeState_e;

  // An entry is idle-expired once the modular distance between the current
  // time and its stamp reaches the timeout; the mask keeps the subtraction
  // inside the TS_NBITS-wide time base so wrap-around is handled for free.
  function automatic logic age_expired(input logic        active,
                                       input logic [31:0] curTs,
                                       input logic [31:0] entryTs,
                                       input int unsigned tsNbits,
                                       input int unsigned timeout);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << tsNbits) - 32'd1;
    diff = (curTs - entryTs) & mask;
    return active && (diff >= timeout);
  endfunction

endpackage

// File: rtl/cla_flow_age_ram.sv
// ---------------------------------------------------------------------------
// cla_flow_age_ram
// 1R1W table of 2^ADDR_NBITS entries x DATA_NBITS bits, registered read.
// The MSB of each entry is its active bit.
// Ports:
//   clk_i          clock
//   we_i           write enable
//   wrIfActive_i   when set, the write only lands if the stored entry is active
//   waddr_i        write address
//   wdata_i        write data
//   raddr_i        read address, data appears on rdata_o one cycle later
//   rdata_o        registered read data (write-first on address collision)
// ---------------------------------------------------------------------------
module cla_flow_age_ram #(
  parameter int unsigned ADDR_NBITS = 4,
  parameter int unsigned DATA_NBITS = 9
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  wrIfActive_i,
  input  logic [ADDR_NBITS-1:0] waddr_i,
  input  logic [DATA_NBITS-1:0] wdata_i,
  input  logic [ADDR_NBITS-1:0] raddr_i,
  output logic [DATA_NBITS-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_NBITS;

  logic [DATA_NBITS-1:0] mem [DEPTH];
  logic [DATA_NBITS-1:0] rdata_q;
  logic                  wrOk;

  // Conditional writes (hit refresh) must not resurrect an entry that has
  // already been released, so they are qualified by the stored active bit.
  assign wrOk = we_i & (~wrIfActive_i | mem[waddr_i][DATA_NBITS-1]);

  // Storage and registered read; a same-address write is forwarded so the
  // reader never sees a stamp that is older than the table contents.
  always_ff @(posedge clk_i) begin
    if (wrOk) begin
      mem[waddr_i] <= wdata_i;
    end
    if (wrOk && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cla_flow_alloc_age.sv
// ---------------------------------------------------------------------------
// cla_flow_alloc_age
// Flow-entry allocator and aging engine. Pops free pointers for new flows,
// stamps entries with the current time, refreshes stamps on lookup hits and
// periodically scans the table, releasing entries idle for AGE_TIMEOUT ticks.
// Optional feature macro: CLA_FLOW_AGE_HIT_REFRESH_EN (adds hit_valid_i /
// hit_ptr_i; without it entries expire AGE_TIMEOUT ticks after allocation).
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   freeb_init_done_i          free list ready; a fall restarts the table
//   freeb_empty_i              free list has no pointer
//   free_buf_ptr_i             free list head
//   free_buf_rd_o              combinational pop of the free list head
//   rel_buf_valid_o/ptr_o      registered one-cycle release of a pointer
//   alloc_req_i                level request for a new entry
//   alloc_ack_o/fail_o/ptr_o   one-cycle completion, fail, allocated pointer
//   hit_valid_i/hit_ptr_i      lookup hit (feature macro only)
//   age_tick_i                 one-cycle time advance
//   age_en_i                   enables scanning
//   table_init_done_o          table clear complete
//   active_count_o             number of active entries
// ---------------------------------------------------------------------------
module cla_flow_alloc_age
  import cla_flow_alloc_age_pkg::*;
#(
  parameter int unsigned BPTR_NBITS  = BPTR_NBITS_DEF,
  parameter int unsigned TS_NBITS    = TS_NBITS_DEF,
  parameter int unsigned AGE_TIMEOUT = AGE_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  freeb_init_done_i,
  input  logic                  freeb_empty_i,
  input  logic [BPTR_NBITS-1:0] free_buf_ptr_i,
  output logic                  free_buf_rd_o,
  output logic                  rel_buf_valid_o,
  output logic [BPTR_NBITS-1:0] rel_buf_ptr_o,
  input  logic                  alloc_req_i,
  output logic                  alloc_ack_o,
  output logic                  alloc_fail_o,
  output logic [BPTR_NBITS-1:0] alloc_ptr_o,
`ifdef CLA_FLOW_AGE_HIT_REFRESH_EN
  input  logic                  hit_valid_i,
  input  logic [BPTR_NBITS-1:0] hit_ptr_i,
`endif
  input  logic                  age_tick_i,
  input  logic                  age_en_i,
  output logic                  table_init_done_o,
  output logic [BPTR_NBITS:0]   active_count_o
);

  localparam int unsigned         ENTRY_NBITS = TS_NBITS + 1;
  localparam logic [BPTR_NBITS-1:0] LAST_IDX  = '1;
  localparam logic [BPTR_NBITS-1:0] IDX_ONE   = 1;
  localparam logic [BPTR_NBITS:0]   CNT_ONE   = 1;
  localparam logic [TS_NBITS-1:0]   TS_ONE    = 1;

  AgeState_e               state_q, state_d;
  logic [BPTR_NBITS-1:0]   idx_q, idx_d;
  logic [TS_NBITS-1:0]     curTs_q, curTs_d;
  logic                    scanPend_q, scanPend_d;
  logic                    initDone_q, initDone_d;
  logic                    freebSeen_q;
  logic                    ack_q, ack_d;
  logic                    fail_q, fail_d;
  logic [BPTR_NBITS-1:0]   allocPtr_q, allocPtr_d;
  logic                    relValid_q, relValid_d;
  logic [BPTR_NBITS-1:0]   relPtr_q, relPtr_d;
  logic [BPTR_NBITS:0]     activeCount_q, activeCount_d;

  logic                    allocGo;
  logic                    allocWe;
  logic                    hitWe;
  logic [BPTR_NBITS-1:0]   hitPtr;
  logic                    freebFall;
  logic                    evalBlocked;
  logic                    expired;
  logic                    scanRel;

  logic                    ramWe;
  logic                    ramWrIfActive;
  logic [BPTR_NBITS-1:0]   ramWaddr;
  logic [ENTRY_NBITS-1:0]  ramWdata;
  logic [ENTRY_NBITS-1:0]  rdData;

  // An allocation is taken only when everything is ready and we are not in
  // the ack cycle; the requester still holds alloc_req_i there.
  assign allocGo = initDone_q & freeb_init_done_i & alloc_req_i & ~ack_q;
  assign allocWe = allocGo & ~freeb_empty_i;

`ifdef CLA_FLOW_AGE_HIT_REFRESH_EN
  // A hit loses the single write port to an allocation in the same cycle.
  assign hitWe  = hit_valid_i & initDone_q & ~allocWe;
  assign hitPtr = hit_ptr_i;
`else
  assign hitWe  = 1'b0;
  assign hitPtr = '0;
`endif

  assign freebFall   = freebSeen_q & ~freeb_init_done_i;
  assign evalBlocked = allocWe | hitWe;
  assign expired     = age_expired(rdData[TS_NBITS], 32'(curTs_q),
                                   32'(rdData[TS_NBITS-1:0]), TS_NBITS,
                                   AGE_TIMEOUT);
  assign scanRel     = (state_q == ST_SCAN_EVAL) & ~evalBlocked & expired &
                       ~freebFall;

  assign free_buf_rd_o = allocWe;

  // Single table write port, priority alloc > hit > clear/scan release.
  always_comb begin
    ramWe         = 1'b0;
    ramWrIfActive = 1'b0;
    ramWaddr      = idx_q;
    ramWdata      = '0;
    if (allocWe) begin
      ramWe    = 1'b1;
      ramWaddr = free_buf_ptr_i;
      ramWdata = {1'b1, curTs_q};
    end else if (hitWe) begin
      ramWe         = 1'b1;
      ramWrIfActive = 1'b1;
      ramWaddr      = hitPtr;
      ramWdata      = {1'b1, curTs_q};
    end else if ((state_q == ST_CLEAR) || scanRel) begin
      ramWe    = 1'b1;
      ramWaddr = idx_q;
      ramWdata = '0;
    end
  end

  cla_flow_age_ram #(
    .ADDR_NBITS (BPTR_NBITS),
    .DATA_NBITS (ENTRY_NBITS)
  ) u_ram (
    .clk_i        (clk_i),
    .we_i         (ramWe),
    .wrIfActive_i (ramWrIfActive),
    .waddr_i      (ramWaddr),
    .wdata_i      (ramWdata),
    .raddr_i      (idx_q),
    .rdata_o      (rdData)
  );

  // Next-state logic for the clear/scan controller, the allocation
  // handshake, the release pulse, the time base and the active counter.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    initDone_d    = initDone_q;
    scanPend_d    = scanPend_q | age_tick_i;
    curTs_d       = age_tick_i ? (curTs_q + TS_ONE) : curTs_q;
    ack_d         = allocGo;
    fail_d        = allocGo & freeb_empty_i;
    allocPtr_d    = allocWe ? free_buf_ptr_i : '0;
    relValid_d    = scanRel;
    relPtr_d      = scanRel ? idx_q : '0;
    activeCount_d = activeCount_q;
    if (allocWe && !scanRel) begin
      activeCount_d = activeCount_q + CNT_ONE;
    end else if (scanRel && !allocWe) begin
      activeCount_d = activeCount_q - CNT_ONE;
    end

    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          initDone_d = 1'b1;
          idx_d      = '0;
        end
      end
      ST_IDLE: begin
        if (scanPend_q && age_en_i && freeb_init_done_i) begin
          state_d    = ST_SCAN_RD;
          idx_d      = '0;
          // A tick in this very cycle still queues the following scan.
          scanPend_d = age_tick_i;
        end
      end
      ST_SCAN_RD: begin
        state_d = ST_SCAN_EVAL;
      end
      ST_SCAN_EVAL: begin
        // A blocked evaluation re-reads the same index, since its read data
        // may predate the write that just took the port.
        if (evalBlocked) begin
          state_d = ST_SCAN_RD;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN_RD;
          idx_d   = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase

    // Losing the free list invalidates every pointer we hold.
    if (freebFall) begin
      state_d       = ST_CLEAR;
      idx_d         = '0;
      initDone_d    = 1'b0;
      scanPend_d    = 1'b0;
      curTs_d       = '0;
      activeCount_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_CLEAR;
      idx_q         <= '0;
      curTs_q       <= '0;
      scanPend_q    <= 1'b0;
      initDone_q    <= 1'b0;
      freebSeen_q   <= 1'b0;
      ack_q         <= 1'b0;
      fail_q        <= 1'b0;
      allocPtr_q    <= '0;
      relValid_q    <= 1'b0;
      relPtr_q      <= '0;
      activeCount_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      curTs_q       <= curTs_d;
      scanPend_q    <= scanPend_d;
      initDone_q    <= initDone_d;
      freebSeen_q   <= freeb_init_done_i;
      ack_q         <= ack_d;
      fail_q        <= fail_d;
      allocPtr_q    <= allocPtr_d;
      relValid_q    <= relValid_d;
      relPtr_q      <= relPtr_d;
      activeCount_q <= activeCount_d;
    end
  end

  assign rel_buf_valid_o   = relValid_q;
  assign rel_buf_ptr_o     = relPtr_q;
  assign alloc_ack_o       = ack_q;
  assign alloc_fail_o      = fail_q;
  assign alloc_ptr_o       = allocPtr_q;
  assign table_init_done_o = initDone_q;
  assign active_count_o    = activeCount_q;

endmodule

// File: tb/tb_cla_flow_alloc_age.sv
// ---------------------------------------------------------------------------
// tb_cla_flow_alloc_age
// Directed bench for cla_flow_alloc_age with a scoreboard: expected
// allocation results and expected releases are queued as stimulus is
// driven and consumed when the DUT pulses alloc_ack_o / rel_buf_valid_o.
// Hit-refresh steps are present only with CLA_FLOW_AGE_HIT_REFRESH_EN.
// ---------------------------------------------------------------------------
module tb_cla_flow_alloc_age;
  import cla_flow_alloc_age_pkg::*;

  localparam int unsigned BPTR    = 4;
  localparam int unsigned TSN     = 8;
  localparam int unsigned TIMEOUT = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            freebInitDone;
  logic            freebEmpty;
  logic [BPTR-1:0] freeBufPtr;
  logic            freeBufRd;
  logic            relValid;
  logic [BPTR-1:0] relPtr;
  logic            allocReq;
  logic            allocAck;
  logic            allocFail;
  logic [BPTR-1:0] allocPtr;
`ifdef CLA_FLOW_AGE_HIT_REFRESH_EN
  logic            hitValid;
  logic [BPTR-1:0] hitPtr;
`endif
  logic            ageTick;
  logic            ageEn;
  logic            tableInitDone;
  logic [BPTR:0]   activeCount;

  typedef struct packed {
    logic            fail;
    logic [BPTR-1:0] ptr;
  } AllocExp_t;

  AllocExp_t       allocQ[$];
  logic [BPTR-1:0] relQ[$];
  AllocExp_t       monAlloc;
  logic [BPTR-1:0] monRel;

  int nVectors     = 0;
  int nMiscompares = 0;
  int expCount     = 0;
  int cyc;
  logic found;

  always #5 clock = ~clock;

  cla_flow_alloc_age #(
    .BPTR_NBITS  (BPTR),
    .TS_NBITS    (TSN),
    .AGE_TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i             (clock),
    .rst_i             (reset),
    .freeb_init_done_i (freebInitDone),
    .freeb_empty_i     (freebEmpty),
    .free_buf_ptr_i    (freeBufPtr),
    .free_buf_rd_o     (freeBufRd),
    .rel_buf_valid_o   (relValid),
    .rel_buf_ptr_o     (relPtr),
    .alloc_req_i       (allocReq),
    .alloc_ack_o       (allocAck),
    .alloc_fail_o      (allocFail),
    .alloc_ptr_o       (allocPtr),
`ifdef CLA_FLOW_AGE_HIT_REFRESH_EN
    .hit_valid_i       (hitValid),
    .hit_ptr_i         (hitPtr),
`endif
    .age_tick_i        (ageTick),
    .age_en_i          (ageEn),
    .table_init_done_o (tableInitDone),
    .active_count_o    (activeCount)
  );

  // One comparison point: count it, and on a miss count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the free-list side of the allocation request for this cycle.
  task automatic applyStimulus(input logic req, input logic empty,
                               input logic [BPTR-1:0] ptr);
    allocReq   = req;
    freebEmpty = empty;
    freeBufPtr = ptr;
  endtask

  // Full requester handshake, entered and left at posedge+1.
  task automatic doAlloc(input logic [BPTR-1:0] ptr, input logic empty,
                         input logic checkCount);
    AllocExp_t e;
    e.fail = empty;
    e.ptr  = empty ? '0 : ptr;
    applyStimulus(1'b1, empty, ptr);
    allocQ.push_back(e);
    if (!empty) expCount++;
    @(negedge clock);
    checkOutput("pop_strobe", 32'(freeBufRd), 32'(!empty));
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("ack_pulse", 32'(allocAck), 32'd1);
    checkOutput("no_pop_in_ack", 32'(freeBufRd), 32'd0);
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, '0);
    @(negedge clock);
    if (checkCount) checkOutput("count_after_alloc", 32'(activeCount), 32'(expCount));
    @(posedge clock); #1;
  endtask

  // One age tick, then enough cycles for a full 16-entry scan to finish.
  task automatic doTick();
    ageTick = 1'b1;
    @(posedge clock); #1;
    ageTick = 1'b0;
    repeat (40) @(posedge clock);
    #1;
  endtask

  // Scoreboard consumer for acks and releases.
  always @(negedge clock) begin
    if (!reset) begin
      if (allocAck) begin
        if (allocQ.size() == 0) begin
          checkOutput("unexpected_ack", 32'(allocAck), 32'd0);
        end else begin
          monAlloc = allocQ.pop_front();
          checkOutput("ack_fail", 32'(allocFail), 32'(monAlloc.fail));
          if (!monAlloc.fail) checkOutput("ack_ptr", 32'(allocPtr), 32'(monAlloc.ptr));
        end
      end
      if (relValid) begin
        if (relQ.size() == 0) begin
          checkOutput("unexpected_release", 32'(relValid), 32'd0);
        end else begin
          monRel = relQ.pop_front();
          checkOutput("release_ptr", 32'(relPtr), 32'(monRel));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    freebInitDone = 1'b1;
    ageTick       = 1'b0;
    ageEn         = 1'b0;
`ifdef CLA_FLOW_AGE_HIT_REFRESH_EN
    hitValid      = 1'b0;
    hitPtr        = '0;
`endif
    applyStimulus(1'b0, 1'b0, '0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_init_done", 32'(tableInitDone), 32'd0);
    checkOutput("rst_count", 32'(activeCount), 32'd0);
    checkOutput("rst_ack", 32'(allocAck), 32'd0);
    checkOutput("rst_rel", 32'(relValid), 32'd0);
    checkOutput("rst_pop", 32'(freeBufRd), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Table clear takes one cycle per entry.
    cyc   = 0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (tableInitDone) found = 1'b1;
    end
    checkOutput("init_cycles", 32'(cyc), 32'd16);
    @(posedge clock); #1;
    ageEn = 1'b1;

    // Allocation, empty allocation, then aging with distinct stamps.
    doAlloc(4'd5, 1'b0, 1'b1);
    doAlloc(4'd9, 1'b1, 1'b1);
    doTick();
    doAlloc(4'd3, 1'b0, 1'b1);
    doTick();
    doTick();
    relQ.push_back(4'd5);
    expCount--;
    doTick();
    checkOutput("rel5_seen", 32'(relQ.size()), 32'd0);
    checkOutput("count_after_rel5", 32'(activeCount), 32'(expCount));
    relQ.push_back(4'd3);
    expCount--;
    doTick();
    checkOutput("rel3_seen", 32'(relQ.size()), 32'd0);
    checkOutput("count_after_rel3", 32'(activeCount), 32'(expCount));

    // Allocation colliding with the evaluation of an expired entry.
    doAlloc(4'd8, 1'b0, 1'b1);
    doAlloc(4'd9, 1'b0, 1'b1);
    doTick();
    doTick();
    doTick();
    relQ.push_back(4'd8);
    relQ.push_back(4'd9);
    expCount -= 2;
    ageTick = 1'b1;
    @(posedge clock); #1;
    ageTick = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (dut.state_q == ST_SCAN_EVAL && dut.idx_q == 4'd8) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    checkOutput("eval8_reached", 32'(found), 32'd1);
    doAlloc(4'd12, 1'b0, 1'b0);
    repeat (40) @(posedge clock);
    #1;
    checkOutput("collision_rels_seen", 32'(relQ.size()), 32'd0);
    checkOutput("count_after_collision", 32'(activeCount), 32'(expCount));

    // Free-list re-init in the middle of a scan that would release ptr 12.
    doTick();
    doTick();
    doTick();
    ageTick = 1'b1;
    @(posedge clock); #1;
    ageTick = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (dut.state_q == ST_SCAN_RD && dut.idx_q == 4'd4) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    checkOutput("scan_rd4_reached", 32'(found), 32'd1);
    freebInitDone = 1'b0;
    expCount      = 0;
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("reinit_init_done", 32'(tableInitDone), 32'd0);
    checkOutput("reinit_count", 32'(activeCount), 32'd0);
    repeat (40) @(posedge clock);
    #1;
    freebInitDone = 1'b1;
    @(negedge clock);
    checkOutput("reinit_table_ready", 32'(tableInitDone), 32'd1);
    checkOutput("reinit_count_held", 32'(activeCount), 32'd0);
    @(posedge clock); #1;

    // Allocation and expiry still work after the re-init.
    doAlloc(4'd2, 1'b0, 1'b1);
    doTick();
    doTick();
    doTick();
    relQ.push_back(4'd2);
    expCount--;
    doTick();
    checkOutput("rel2_seen", 32'(relQ.size()), 32'd0);
    checkOutput("count_after_rel2", 32'(activeCount), 32'(expCount));

`ifdef CLA_FLOW_AGE_HIT_REFRESH_EN
    // Hit at the third tick postpones expiry to the seventh.
    doAlloc(4'd3, 1'b0, 1'b1);
    doTick();
    doTick();
    doTick();
    hitValid = 1'b1;
    hitPtr   = 4'd3;
    @(posedge clock); #1;
    hitValid = 1'b0;
    doTick();
    checkOutput("hit_kept_count", 32'(activeCount), 32'(expCount));
    doTick();
    doTick();
    relQ.push_back(4'd3);
    expCount--;
    doTick();
    checkOutput("hit_rel_seen", 32'(relQ.size()), 32'd0);
    checkOutput("count_after_hit_rel", 32'(activeCount), 32'(expCount));
`endif

    checkOutput("alloc_queue_drained", 32'(allocQ.size()), 32'd0);
    checkOutput("rel_queue_drained", 32'(relQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/cla_flow_alloc_age.md
# cla_flow_alloc_age

Flow-entry allocator and aging engine for the classifier flow value table. It is the client of the flow free list: it pops free pointers for new flows and returns pointers of flows that have timed out. It keeps a per-entry active bit and timestamp, refreshes timestamps on lookup hits, and periodically scans the table to release idle entries.

## Interface
- BPTR_NBITS, `FLOW_VALUE_DEPTH_NBITS, flow entry pointer width; the table has 2^BPTR_NBITS entries
- TS_NBITS, 8, timestamp width
- AGE_TIMEOUT, 4, number of age ticks of idleness before an entry expires; legal range 1..2^TS_NBITS-1
- clk  in  1  sole clock
- rst  in  1  reset, connected through `RESET_SIG; synchronous, active-high
- freeb_init_done  in  1  free list ready
- freeb_empty  in  1  free list has no pointer
- free_buf_ptr  in  BPTR_NBITS  free list head, valid when freeb_empty=0
- free_buf_rd  out  1  combinational pop of the free list head
- rel_buf_valid  out  1  registered one-cycle release pulse
- rel_buf_ptr  out  BPTR_NBITS  pointer being released
- alloc_req  in  1  level request for a new flow entry
- alloc_ack  out  1  one-cycle pulse completing a request
- alloc_fail  out  1  qualifies alloc_ack; no entry was available
- alloc_ptr  out  BPTR_NBITS  allocated pointer, valid with alloc_ack=1 and alloc_fail=0
- hit_valid  in  1  lookup hit on an entry
- hit_ptr  in  BPTR_NBITS  pointer that was hit
- age_tick  in  1  one-cycle pulse that advances time
- age_en  in  1  enables scanning
- table_init_done  out  1  table clear is complete
- active_count  out  BPTR_NBITS+1  number of active entries

## Operation
- **Reset values:** all outputs reset to 0. cur_ts resets to 0. State resets to CLEAR.
- **State machine**
  - CLEAR: writes active=0 to index 0 .. 2^N-1, one entry per cycle. At the last index the block moves to IDLE and sets table_init_done=1.
  - IDLE -> SCAN_RD when a scan is pending, age_en=1 and freeb_init_done=1.
  - SCAN_RD: reads the entry at scan_idx.
  - SCAN_EVAL: evaluates the read data.
    - If the entry is expired, the block writes active=0, pulses rel_buf_valid with rel_buf_ptr=scan_idx, and decrements active_count.
    - If scan_idx is the last index, the block returns to IDLE. Otherwise it increments scan_idx and goes to SCAN_RD.
- **Expiry rule:** an entry is expired when active=1 and (cur_ts - ts) mod 2^TS_NBITS >= AGE_TIMEOUT.
- **Time base:** cur_ts increments on each age_tick, wrapping at 2^TS_NBITS.
- **Scan pending flag:** age_tick sets the flag, and SCAN_RD entry clears it. A tick during a scan therefore queues exactly one more scan; further ticks during the same scan are not queued separately.
- **Allocation**
  - Allowed when table_init_done=1, freeb_init_done=1, alloc_req=1, and the cycle is not an ack cycle.
  - If freeb_empty=0: free_buf_rd=1 in that cycle and the block writes active=1, ts=cur_ts to free_buf_ptr. Next cycle alloc_ack=1 and alloc_ptr=the popped pointer.
  - If freeb_empty=1: next cycle alloc_ack=1 and alloc_fail=1.
- **Table write port priority:** alloc > hit > scan.
  - A hit writes ts=cur_ts only if the entry is active.
  - When a SCAN_EVAL is blocked by an alloc or hit write, it does not write, release or advance. It returns to SCAN_RD for the same index, which discards the stale read data.
- **active_count:** +1 on a successful alloc, -1 on a release, unchanged when both happen in the same cycle.
- **Free-list re-init:** if freeb_init_done falls, the block aborts any scan, forces table_init_done=0, drops the pending scan, and returns to CLEAR. active_count and cur_ts return to 0. Requests arriving while not ready are held, not failed.

## Timing
- alloc_req to free_buf_rd: 0 cycles. alloc_req to alloc_ack: 1 cycle.
- Requester handshake: the requester holds alloc_req until it sees alloc_ack and drops it in the following cycle. alloc_req is ignored in the ack cycle, so the block completes at most one allocation every 2 cycles.
- Scan cost: minimum 2 cycles per entry, so a full scan takes 2·2^N cycles plus any stall cycles.
- Release: rel_buf_valid is asserted in the cycle after SCAN_EVAL decides. At most one release every 2 cycles.
- Table read latency is 1 cycle (registered read). A hit in the same cycle as an alloc is dropped, because the table has a single write port.

## Configuration
- CLA_FLOW_AGE_HIT_REFRESH_EN
  - Defined: hit_valid/hit_ptr exist, and a hit refreshes ts.
  - Undefined: the hit ports are absent, and an entry expires AGE_TIMEOUT ticks after allocation regardless of traffic.

## Structure
- defines.vh holds the state encodings (CLEAR/IDLE/SCAN_RD/SCAN_EVAL), the entry field layout {active, ts[TS_NBITS-1:0]} and the default TS_NBITS.
- Sub-module cla_flow_age_ram: 1R1W array of 2^BPTR_NBITS x (TS_NBITS+1) with registered read.

## Test plan
- **Reset then init:** reset, freeb_init_done=1 -> table_init_done rises after 2^N cycles; all outputs are 0 until then.
- **Alloc pop and ack:** alloc_req with free_buf_ptr=5 -> free_buf_rd=1 at t, then alloc_ack=1 and alloc_ptr=5 at t+1; active_count=1.
- **Alloc on empty:** freeb_empty=1 with alloc_req -> alloc_ack=1, alloc_fail=1, no free_buf_rd, active_count unchanged.
- **Aging:** allocate ptr 3 with AGE_TIMEOUT=4, then send 4 age_ticks with age_en=1 -> exactly one rel_buf_valid with rel_buf_ptr=3; active_count returns to 0.
- **Hit refresh (macro defined):** hit on ptr 3 at tick 3 -> no release at tick 4; release occurs after tick 7.
- **Collision and re-init:** hit or alloc colliding with SCAN_EVAL -> the entry is re-read and not lost. Dropping freeb_init_done mid-scan -> CLEAR is re-entered and there is no further rel_buf_valid.
